// File: rtl/im_boot_loader.sv
// ---------------------------------------------------------------------------
// im_boot_loader
//
// Owns the single port of the instruction-memory block RAM. In normal run
// mode the IF-stage fetch address is passed straight through. A load request
// holds the CPU and takes over the port. The loader then receives a 16-bit
// little-endian word count followed by that many 32-bit little-endian words
// from the UART receiver and writes them from address 0 upward. When the
// load completes the CPU is released and fetch restarts from the reset PC.
//
// Ports:
//   Clock       system clock, rising edge
//   Reset       asynchronous, active-low reset
//   Load_Req    one-cycle pulse requesting a program load
//   Rx_Data     byte from UART receiver
//   Rx_Valid    one-cycle pulse per received byte
//   Fetch_Addr  IF-stage word address
//   Im_Addr     address to IM core (fetch address in RUN, write pointer otherwise)
//   Im_We       IM write enable, one cycle per assembled word
//   Im_Din      IM write data
//   Cpu_Hold    holds the CPU in reset while a load is in progress
//   Load_Done   one-cycle pulse on successful completion
//   Load_Error  load-failure flag, held until the next load request
//   Word_Count  words written in the current/last load
// ---------------------------------------------------------------------------
module im_boot_loader #(
    parameter int ADDR_W  = 11,
    parameter int TIMEOUT = 50000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Load_Req,
    input  logic [7:0]        Rx_Data,
    input  logic              Rx_Valid,
    input  logic [ADDR_W-1:0] Fetch_Addr,
    output logic [ADDR_W-1:0] Im_Addr,
    output logic              Im_We,
    output logic [31:0]       Im_Din,
    output logic              Cpu_Hold,
    output logic              Load_Done,
    output logic              Load_Error,
    output logic [ADDR_W:0]   Word_Count
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    // The counter reaches TIMEOUT-1 on the edge that leaves a register value
    // of TIMEOUT-2 behind, so the abort decision is taken one value early.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 2);
    localparam logic [31:0]      DEPTH    = 32'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_RUN,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_reg, state_next;
    logic [7:0]        len_lo_reg, len_lo_next;
    logic [15:0]       n_reg, n_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [ADDR_W:0]   wc_reg, wc_next;
    logic [1:0]        idx_reg, idx_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic              we_reg, we_next;

    logic [15:0]       len_word;
    logic [ADDR_W:0]   wc_inc;
    logic              in_load;
    logic              timeout_hit;
    logic              byte_take;
    logic [31:0]       din_w;

    assign len_word    = {Rx_Data, len_lo_reg};
    assign wc_inc      = wc_reg + 1'b1;
    assign in_load     = (state_reg == S_LEN0) || (state_reg == S_LEN1) ||
                         (state_reg == S_DATA);
    assign timeout_hit = in_load && !Rx_Valid && (tmo_reg == TMO_LAST);
    assign byte_take   = (state_reg == S_DATA) && Rx_Valid;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg  <= S_RUN;
            len_lo_reg <= '0;
            n_reg      <= '0;
            ptr_reg    <= '0;
            wc_reg     <= '0;
            idx_reg    <= '0;
            tmo_reg    <= '0;
            we_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            len_lo_reg <= len_lo_next;
            n_reg      <= n_next;
            ptr_reg    <= ptr_next;
            wc_reg     <= wc_next;
            idx_reg    <= idx_next;
            tmo_reg    <= tmo_next;
            we_reg     <= we_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        len_lo_next = len_lo_reg;
        n_next      = n_reg;
        ptr_next    = ptr_reg;
        wc_next     = wc_reg;
        idx_next    = idx_reg;
        tmo_next    = tmo_reg;
        we_next     = 1'b0;

        if (in_load) begin
            tmo_next = Rx_Valid ? '0 : tmo_reg + 1'b1;
        end

        unique case (state_reg)
            S_RUN: begin
                // Bytes arriving in run mode (even alongside Load_Req) are dropped.
                if (Load_Req) begin
                    state_next = S_LEN0;
                    tmo_next   = '0;
                end
            end

            S_LEN0: begin
                if (Rx_Valid) begin
                    len_lo_next = Rx_Data;
                    state_next  = S_LEN1;
                end else if (timeout_hit) begin
                    state_next = S_ERR;
                end
            end

            S_LEN1: begin
                if (Rx_Valid) begin
                    n_next = len_word;
                    // Word_Count reflects the current load as soon as its
                    // length is known, including empty and rejected loads.
                    ptr_next = '0;
                    idx_next = '0;
                    wc_next  = '0;
                    if (len_word == 16'd0) begin
                        state_next = S_DONE;
                    end else if (32'(len_word) > DEPTH) begin
                        state_next = S_ERR;
                    end else begin
                        state_next = S_DATA;
                    end
                end else if (timeout_hit) begin
                    state_next = S_ERR;
                end
            end

            S_DATA: begin
                if (timeout_hit) begin
                    state_next = S_ERR;
                end
                // The receiver is never stalled: a byte during the write
                // cycle simply starts the next word.
                if (Rx_Valid) begin
                    idx_next = idx_reg + 1'b1;
                    if (idx_reg == 2'd3) begin
                        we_next = 1'b1;
                    end
                end
                // Pointer and count advance once the write cycle is over.
                if (we_reg) begin
                    ptr_next = ptr_reg + 1'b1;
                    wc_next  = wc_inc;
                    if (32'(wc_inc) == 32'(n_reg)) begin
                        state_next = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_next = S_RUN;
            end

            S_ERR: begin
                if (Load_Req) begin
                    state_next = S_LEN0;
                    tmo_next   = '0;
                end
            end

            default: begin
                state_next = S_RUN;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Write-data byte lanes: each received byte lands directly in its lane,
    // so the full word is present on the same edge that raises Im_We.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    lane_reg <= '0;
                end else if (byte_take && (idx_reg == 2'(gi))) begin
                    lane_reg <= Rx_Data;
                end
            end

            assign din_w[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign Im_Addr    = (state_reg == S_RUN) ? Fetch_Addr : ptr_reg;
    assign Im_We      = we_reg;
    assign Im_Din     = din_w;
    assign Cpu_Hold   = (state_reg != S_RUN);
    assign Load_Done  = (state_reg == S_DONE);
    assign Load_Error = (state_reg == S_ERR);
    assign Word_Count = wc_reg;

endmodule

// File: tb/tb_im_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_im_boot_loader
//
// Drives byte streams into im_boot_loader and checks the RAM writes it
// produces against a queue of expected (address, data) pairs, plus the
// hold/done/error handshakes around each load.
// ---------------------------------------------------------------------------
module tb_im_boot_loader;

    localparam int ADDR_W  = 11;
    localparam int TIMEOUT = 16;

    logic              Clock;
    logic              Reset;
    logic              Load_Req;
    logic [7:0]        Rx_Data;
    logic              Rx_Valid;
    logic [ADDR_W-1:0] Fetch_Addr;
    logic [ADDR_W-1:0] Im_Addr;
    logic              Im_We;
    logic [31:0]       Im_Din;
    logic              Cpu_Hold;
    logic              Load_Done;
    logic              Load_Error;
    logic [ADDR_W:0]   Word_Count;

    im_boot_loader #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Load_Req   (Load_Req),
        .Rx_Data    (Rx_Data),
        .Rx_Valid   (Rx_Valid),
        .Fetch_Addr (Fetch_Addr),
        .Im_Addr    (Im_Addr),
        .Im_We      (Im_We),
        .Im_Din     (Im_Din),
        .Cpu_Hold   (Cpu_Hold),
        .Load_Done  (Load_Done),
        .Load_Error (Load_Error),
        .Word_Count (Word_Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t exp_q[$];
    wr_t exp_wr;
    int  err_cnt  = 0;
    int  chk_cnt  = 0;
    int  done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every write cycle must match the oldest expected write.
    always @(negedge Clock) begin
        if (Im_We === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("we_unexpected", 64'(Im_Addr), 64'hFFFF);
            end else begin
                exp_wr = exp_q.pop_front();
                $display("write addr=0x%03h data=0x%08h", Im_Addr, Im_Din);
                chk("wr_addr", 64'(Im_Addr), 64'(exp_wr.addr));
                chk("wr_data", 64'(Im_Din), 64'(exp_wr.data));
            end
        end
        if (Load_Done === 1'b1) begin
            done_cnt++;
        end
    end

    // Stimulus tasks start and end at 1 ns after a rising edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        Rx_Data  = b;
        Rx_Valid = 1'b1;
        step();
        Rx_Valid = 1'b0;
    endtask

    task automatic pulse_load();
        Load_Req = 1'b1;
        step();
        Load_Req = 1'b0;
    endtask

    task automatic push_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
        send_byte(d[7:0]);
        send_byte(d[15:8]);
        send_byte(d[23:16]);
        send_byte(d[31:24]);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (Load_Done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (Load_Done !== 1'b1) begin
            chk(tag, 64'(Load_Done), 64'd1);
        end
    endtask

    int done_before;

    initial begin
        Reset      = 1'b0;
        Load_Req   = 1'b0;
        Rx_Data    = 8'h00;
        Rx_Valid   = 1'b0;
        Fetch_Addr = 11'h005;

        // ---- reset state ----
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("rst_we",    64'(Im_We), 64'd0);
        chk("rst_hold",  64'(Cpu_Hold), 64'd0);
        chk("rst_done",  64'(Load_Done), 64'd0);
        chk("rst_err",   64'(Load_Error), 64'd0);
        chk("rst_wc",    64'(Word_Count), 64'd0);
        chk("rst_din",   64'(Im_Din), 64'd0);
        step();
        Reset = 1'b1;
        step();
        chk("run_addr",  64'(Im_Addr), 64'h005);
        Fetch_Addr = 11'h3C1;
        #1;
        chk("run_addr_comb", 64'(Im_Addr), 64'h3C1);
        chk("run_hold",  64'(Cpu_Hold), 64'd0);

        // ---- two-word load, back-to-back bytes; byte alongside Load_Req dropped ----
        $display("load: 2 words");
        done_before = done_cnt;
        Rx_Data  = 8'h99;
        Rx_Valid = 1'b1;
        pulse_load();
        chk("hold_after_req", 64'(Cpu_Hold), 64'd1);
        send_byte(8'h02);
        send_byte(8'h00);
        exp_q.push_back('{addr: 11'd0, data: 32'h12345678});
        send_byte(8'h78);
        send_byte(8'h56);
        Load_Req = 1'b1;                 // ignored mid-DATA
        send_byte(8'h34);
        Load_Req = 1'b0;
        send_byte(8'h12);
        push_word(11'd1, 32'hDEADBEEF);
        chk("hold_in_load", 64'(Cpu_Hold), 64'd1);
        wait_done("done_2w_timeout", 20);
        chk("done_wc",   64'(Word_Count), 64'd2);
        chk("done_hold", 64'(Cpu_Hold), 64'd1);
        step();
        chk("post_done_hold", 64'(Cpu_Hold), 64'd0);
        chk("post_done_pulse", 64'(Load_Done), 64'd0);
        chk("done_pulses", 64'(done_cnt - done_before), 64'd1);
        chk("q_empty_2w", 64'(exp_q.size()), 64'd0);
        Fetch_Addr = 11'h2A5;
        #1;
        chk("run_addr_after", 64'(Im_Addr), 64'h2A5);

        // ---- zero-length load ----
        $display("load: zero length");
        done_before = done_cnt;
        pulse_load();
        send_byte(8'h00);
        send_byte(8'h00);
        wait_done("done_0w_timeout", 5);
        chk("zero_wc", 64'(Word_Count), 64'd0);
        step();
        chk("zero_pulses", 64'(done_cnt - done_before), 64'd1);
        chk("zero_hold", 64'(Cpu_Hold), 64'd0);

        // ---- oversize length -> ERR, exit on Load_Req ----
        $display("load: oversize length 0x0801");
        pulse_load();
        send_byte(8'h01);
        send_byte(8'h08);
        chk("big_err", 64'(Load_Error), 64'd1);
        repeat (5) step();
        chk("big_err_held", 64'(Load_Error), 64'd1);
        chk("big_hold", 64'(Cpu_Hold), 64'd1);
        pulse_load();
        chk("err_exit_clr", 64'(Load_Error), 64'd0);
        chk("err_exit_hold", 64'(Cpu_Hold), 64'd1);
        done_before = done_cnt;
        send_byte(8'h00);
        send_byte(8'h00);
        wait_done("err_relaunch_timeout", 5);
        step();
        chk("relaunch_pulses", 64'(done_cnt - done_before), 64'd1);

        // ---- timeout inside DATA with a partial word ----
        $display("load: timeout after partial word");
        pulse_load();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        pulse_load();                    // ignored mid-DATA
        send_byte(8'hBB);
        repeat (TIMEOUT - 2) step();
        chk("tmo_early", 64'(Load_Error), 64'd0);
        step();
        chk("tmo_err", 64'(Load_Error), 64'd1);
        chk("tmo_hold", 64'(Cpu_Hold), 64'd1);
        chk("tmo_wc", 64'(Word_Count), 64'd0);

        // ---- asynchronous reset mid-DATA (byte index 2) ----
        $display("load: reset mid-word");
        pulse_load();
        send_byte(8'h04);
        send_byte(8'h00);
        push_word(11'd0, 32'h04030201);
        step();
        step();
        send_byte(8'h11);
        send_byte(8'h22);
        chk("mid_wc", 64'(Word_Count), 64'd1);
        chk("mid_addr", 64'(Im_Addr), 64'd1);
        Fetch_Addr = 11'h123;
        #2;
        Reset = 1'b0;
        #1;
        chk("async_hold", 64'(Cpu_Hold), 64'd0);
        chk("async_we",   64'(Im_We), 64'd0);
        chk("async_wc",   64'(Word_Count), 64'd0);
        chk("async_din",  64'(Im_Din), 64'd0);
        chk("async_err",  64'(Load_Error), 64'd0);
        chk("async_addr", 64'(Im_Addr), 64'h123);
        step();
        Reset = 1'b1;
        Fetch_Addr = 11'h7FF;
        step();
        chk("rel_addr", 64'(Im_Addr), 64'h7FF);
        chk("rel_hold", 64'(Cpu_Hold), 64'd0);
        chk("q_empty_end", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", chk_cnt);
        $fatal(1);
    end

endmodule
